// File: rtl/mem_out_pkg.sv
// Shared definitions for the banked output memory: default geometry,
// accumulate state encoding and a bank-select width helper.
package mem_out_pkg;

   localparam int DEF_WORD_W      = 32;
   localparam int DEF_NUM_BANKS   = 4;
   localparam int DEF_BANK_ADDR_W = 8;

   // Write-path state: IDLE accepts writes, ACC_WB performs the accumulate write-back.
   typedef enum logic {
      IDLE   = 1'b0,
      ACC_WB = 1'b1
   } state_t;

   // Width of the bank-select field; never narrower than one bit.
   function automatic int sel_width(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 1;
   endfunction

endpackage

// File: rtl/mem_out_bank.sv
// Single-port memory bank, 2^ADDR_W x WORD_W, active-low chip enable and
// write enable, synchronous read with one cycle of latency. Contents are
// never reset; dout holds its value until the next read.
module mem_out_bank #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              cen,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];

   // Enabled access: write when wen is low, otherwise registered read.
   always_ff @(posedge clk) begin
      if (!cen) begin
         if (!wen) begin
            mem[addr] <= din;
         end else begin
            dout <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mem_out_banked.sv
// Banked output memory with one write path and one read path.
// Address MSBs select a bank, LSBs select the word inside it. The write path
// owns its bank for the cycle; a read to that bank is refused.
// Optional macro MEM_OUT_ACC_EN adds read-modify-write accumulate writes
// (IDLE reads the old word, ACC_WB writes old+data back).
module mem_out_banked
   import mem_out_pkg::*;
#(
   parameter  int WORD_W      = DEF_WORD_W,
   parameter  int NUM_BANKS   = DEF_NUM_BANKS,
   parameter  int BANK_ADDR_W = DEF_BANK_ADDR_W,
   localparam int SEL_W       = sel_width(NUM_BANKS),
   localparam int ADDR_W      = SEL_W + BANK_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              wr_acc,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_data_valid,
   output logic [WORD_W-1:0] rd_data
);

   logic [SEL_W-1:0]       wr_bank;
   logic [SEL_W-1:0]       rd_bank;
   logic [BANK_ADDR_W-1:0] wr_word;
   logic [BANK_ADDR_W-1:0] rd_word;
   logic                   rd_fire;
   logic [SEL_W-1:0]       rd_sel_reg;

   // Write-path request presented to the banks this cycle.
   logic                   wp_active;
   logic                   wp_write;
   logic [SEL_W-1:0]       wp_bank;
   logic [BANK_ADDR_W-1:0] wp_word;
   logic [WORD_W-1:0]      wp_data;

   logic [WORD_W-1:0]      bank_dout [NUM_BANKS];

   assign wr_bank = wr_addr[ADDR_W-1:BANK_ADDR_W];
   assign wr_word = wr_addr[BANK_ADDR_W-1:0];
   assign rd_bank = rd_addr[ADDR_W-1:BANK_ADDR_W];
   assign rd_word = rd_addr[BANK_ADDR_W-1:0];

`ifdef MEM_OUT_ACC_EN
   state_t                 state_reg;
   state_t                 state_next;
   logic                   wr_fire;
   logic [SEL_W-1:0]       acc_bank_reg;
   logic [BANK_ADDR_W-1:0] acc_word_reg;
   logic [WORD_W-1:0]      acc_data_reg;
   logic [WORD_W-1:0]      acc_sum;

   assign wr_fire = wr_valid && wr_ready;
   // Old word arrives from the bank in ACC_WB; the sum wraps at WORD_W bits.
   assign acc_sum = bank_dout[acc_bank_reg] + acc_data_reg;

   // State register; reset drops any pending write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Capture the accumulate target and addend when it is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_bank_reg <= '0;
         acc_word_reg <= '0;
         acc_data_reg <= '0;
      end else if (wr_fire && wr_acc) begin
         acc_bank_reg <= wr_bank;
         acc_word_reg <= wr_word;
         acc_data_reg <= wr_data;
      end
   end

   // Next state and write-path selection: IDLE serves the incoming write,
   // ACC_WB writes the sum back and blocks new writes.
   always_comb begin
      state_next = state_reg;
      wr_ready   = 1'b0;
      wp_active  = 1'b0;
      wp_write   = 1'b0;
      wp_bank    = wr_bank;
      wp_word    = wr_word;
      wp_data    = wr_data;
      case (state_reg)
         IDLE: begin
            wr_ready  = 1'b1;
            wp_active = wr_valid;
            wp_write  = wr_valid && !wr_acc;
            if (wr_valid && wr_acc) begin
               state_next = ACC_WB;
            end
         end
         ACC_WB: begin
            wp_active  = 1'b1;
            wp_write   = 1'b1;
            wp_bank    = acc_bank_reg;
            wp_word    = acc_word_reg;
            wp_data    = acc_sum;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end
`else
   logic unused_acc;

   // Every write is an overwrite; the accumulate flag has no effect.
   assign unused_acc = wr_acc;
   assign wr_ready   = 1'b1;
   assign wp_active  = wr_valid;
   assign wp_write   = wr_valid;
   assign wp_bank    = wr_bank;
   assign wp_word    = wr_word;
   assign wp_data    = wr_data;
`endif

   // Write path has priority over the read path on a shared bank.
   assign rd_ready = !(wp_active && (rd_bank == wp_bank));
   assign rd_fire  = rd_valid && rd_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         logic                   wp_hit;
         logic                   rd_hit;
         logic                   cen;
         logic                   wen;
         logic [BANK_ADDR_W-1:0] addr;

         assign wp_hit = wp_active && (wp_bank == SEL_W'(gi));
         assign rd_hit = rd_fire && (rd_bank == SEL_W'(gi));
         // Banks are idle while reset is held so their contents survive it.
         assign cen    = rst || !(wp_hit || rd_hit);
         assign wen    = !(wp_hit && wp_write);
         assign addr   = wp_hit ? wp_word : rd_word;

         mem_out_bank #(
            .WORD_W (WORD_W),
            .ADDR_W (BANK_ADDR_W)
         ) u_bank (
            .clk  (clk),
            .cen  (cen),
            .wen  (wen),
            .addr (addr),
            .din  (wp_data),
            .dout (bank_dout[gi])
         );
      end
   endgenerate

   // Remember which bank answers the read and flag the data cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_valid <= 1'b0;
         rd_sel_reg    <= '0;
      end else begin
         rd_data_valid <= rd_fire;
         if (rd_fire) begin
            rd_sel_reg <= rd_bank;
         end
      end
   end

   assign rd_data = rd_data_valid ? bank_dout[rd_sel_reg] : '0;

endmodule

// File: doc/mem_out_banked.md
MEM_OUT_BANKED -- requirements
Module: mem_out_banked

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data word width in bits.
REQ-002 SHALL have parameter NUM_BANKS, default 4, number of single-port banks, power of two, 2..16.
REQ-003 SHALL have parameter BANK_ADDR_W, default 8, word-address width inside one bank (256 words).
REQ-004 SHALL derive ADDR_W = log2(NUM_BANKS)+BANK_ADDR_W; address MSBs select the bank, LSBs the word.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports wr_valid in 1, wr_ready out 1, wr_acc in 1 (1=accumulate, 0=overwrite), wr_addr in ADDR_W, wr_data in WORD_W.
REQ-008 SHALL have ports rd_valid in 1, rd_ready out 1, rd_addr in ADDR_W.
REQ-009 SHALL have ports rd_data_valid out 1, rd_data out WORD_W.

Function
REQ-010 SHALL accept a write when wr_valid&wr_ready, and a read when rd_valid&rd_ready, at the rising edge.
REQ-011 SHALL perform an overwrite (wr_acc=0) in the accept cycle; the bank holds wr_data from the next cycle.
REQ-012 SHALL perform an accumulate (wr_acc=1) as read-modify-write: state IDLE accepts and reads the bank; state ACC_WB writes old+wr_data back one cycle later, then returns to IDLE.
REQ-013 SHALL compute the sum modulo 2^WORD_W, with no saturation or carry output.
REQ-014 SHALL hold wr_ready=0 in ACC_WB and wr_ready=1 in IDLE.
REQ-015 SHALL give the write path bank priority: rd_ready=0 when rd_addr bank equals the bank accessed by the write path this cycle (accepted write in IDLE, or write-back in ACC_WB); otherwise rd_ready=1.
REQ-016 SHALL return read data with latency 1: rd_data_valid=1 for exactly the cycle after a read accept, with rd_data equal to bank contents at accept time.
REQ-017 SHALL route rd_data through a bank-select register captured at read accept, and drive rd_data=0 whenever rd_data_valid=0.
REQ-018 SHALL return, for a read accepted in the ACC_WB cycle of an accumulate to a different bank, the unaffected contents of that bank.
REQ-019 SHALL allow rd_valid and wr_valid to different banks in the same cycle, both accepted.
REQ-020 SHALL drive the wr_ready and rd_ready outputs combinationally from state and addresses only, with no dependence on any *_ready input.

Reset
REQ-021 SHALL, while rst=1, force state IDLE, rd_data_valid=0, rd_data=0, bank-select register 0, and pending accumulate registers 0.
REQ-022 SHALL abandon an accumulate in progress when reset asserts mid-operation; the target word keeps its pre-accumulate value.
REQ-023 SHALL leave memory array contents unchanged by reset.

Configuration
REQ-024 SHALL compile accumulate support only when macro MEM_OUT_ACC_EN is defined.
REQ-025 SHALL, without MEM_OUT_ACC_EN, ignore wr_acc, treat every write as overwrite, tie wr_ready=1, and omit state ACC_WB and the adder.

Structure
REQ-026 SHALL take the state encoding (IDLE, ACC_WB) and default parameter constants from shared package mem_out_pkg.
REQ-027 SHALL instantiate NUM_BANKS copies of sub-module mem_out_bank: 2^BANK_ADDR_W x WORD_W, single port, synchronous read latency 1, active-low CEN/WEN.

Verification
REQ-028 SHALL cover: overwrite addr 0x105 with 0xDEADBEEF, read 0x105 -> rd_data_valid next cycle, rd_data=0xDEADBEEF.
REQ-029 SHALL cover: word 0x010=5, accumulate 7 -> wr_ready low one cycle, later read returns 12; accumulate 0xFFFFFFFF onto 1 -> read returns 0.
REQ-030 SHALL cover: write to bank 2 and read from bank 2 in the same cycle -> rd_ready=0; read of bank 3 in that same cycle -> accepted.
REQ-031 SHALL cover: accumulate to bank 1 with a read of bank 1 in the ACC_WB cycle -> rd_ready=0; read the following cycle returns the summed value.
REQ-032 SHALL cover: rst asserted during ACC_WB of an accumulate of 4 onto 10 -> state IDLE, outputs 0, later read returns 10.
REQ-033 SHALL cover: MEM_OUT_ACC_EN undefined, write wr_acc=1 value 3 onto 9 -> wr_ready stays 1, read returns 3.
